// File: rtl/touch_pkg.sv
// Shared types and constants for the touch conditioning path between the
// touchpad controller and the TFT driver.
package touch_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } touch_state_e;

  localparam int          COORD_W  = 12;
  localparam logic [11:0] NO_TOUCH = 12'd1000;
  localparam int          PANEL_W  = 480;
  localparam int          PANEL_H  = 272;

  localparam int DEF_X_OFFSET = 150;
  localparam int DEF_Y_OFFSET = 300;
  localparam int DEF_X_SHIFT  = 3;
  localparam int DEF_Y_SHIFT  = 4;
  localparam int DEF_X_MAX    = PANEL_W - 1;
  localparam int DEF_Y_MAX    = PANEL_H - 1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } touch_xy_t;

  // Offset with floor at zero (no unsigned wrap), scale down, clamp to panel edge.
  function automatic logic [11:0] calib(input logic [11:0] avg,
                                        input logic [11:0] off,
                                        input int          sh,
                                        input logic [11:0] mx);
    logic [11:0] d;
    d = (avg < off) ? 12'd0 : ((avg - off) >> sh);
    return (d > mx) ? mx : d;
  endfunction

endpackage

// File: rtl/touch_frame_filter_if.sv
// Raw touch samples in, frame-stable coordinates out.
interface touch_frame_filter_if;
  logic [11:0] raw_x;
  logic [11:0] raw_y;
  logic [11:0] raw_z;
  logic        new_frame;
  logic [11:0] touch_x;
  logic [11:0] touch_y;
  logic        touch_valid;
  logic        sample_tick;

  modport master (
    output raw_x, raw_y, raw_z, new_frame,
    input  touch_x, touch_y, touch_valid, sample_tick
  );

  modport slave (
    input  raw_x, raw_y, raw_z, new_frame,
    output touch_x, touch_y, touch_valid, sample_tick
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a third flop giving a one-cycle rising-edge pulse.
// Usable for any slow level/pulse arriving from another clock domain.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic r_s1, r_s2, r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/touch_frame_filter.sv
// Samples raw touch at a fixed rate, debounces press state, averages the last
// four pressed samples, calibrates to panel space and latches once per frame.
module touch_frame_filter
  import touch_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int Z_THRESH   = 256,
  parameter int DEBOUNCE   = 3,
  parameter int X_OFFSET   = DEF_X_OFFSET,
  parameter int Y_OFFSET   = DEF_Y_OFFSET,
  parameter int X_SHIFT    = DEF_X_SHIFT,
  parameter int Y_SHIFT    = DEF_Y_SHIFT,
  parameter int X_MAX      = DEF_X_MAX,
  parameter int Y_MAX      = DEF_Y_MAX
) (
  input logic                 cclk,
  input logic                 rstb,
  touch_frame_filter_if.slave bus
);
  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  // ---------------- sample-rate prescaler ----------------
  logic [PW-1:0] r_presc;
  logic          r_tick;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PW'(SAMPLE_DIV - 1)) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_tick  <= 1'b0;
    end
  end

  // ---------------- frame marker from tft_clk domain ----------------
  logic w_frame_evt;

  sync_edge_detect u_frame_sync (
    .i_clk   (cclk),
    .i_rst_n (rstb),
    .i_d     (bus.new_frame),
    .o_rise  (w_frame_evt)
  );

  // ---------------- press debounce FSM ----------------
  logic          w_hit;
  touch_state_e  r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic          w_push, w_flush;

  assign w_hit     = (bus.raw_z >= 12'(Z_THRESH));
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_push     = 1'b0;
    w_flush    = 1'b0;
    if (r_tick) begin
      case (r_state)
        RELEASED: begin
          if (w_hit) begin
            w_state_nx = PRESS_PEND;
            w_cnt_nx   = CW'(1);
          end
        end
        PRESS_PEND: begin
          if (w_hit) begin
            w_push   = 1'b1;
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == CW'(DEBOUNCE)) begin
              w_state_nx = PRESSED;
              w_cnt_nx   = '0;
            end
          end else begin
            w_state_nx = RELEASED;
            w_cnt_nx   = '0;
            w_flush    = 1'b1;
          end
        end
        PRESSED: begin
          if (w_hit) begin
            w_push = 1'b1;
          end else begin
            w_state_nx = REL_PEND;
            w_cnt_nx   = CW'(1);
          end
        end
        REL_PEND: begin
          if (w_hit) begin
            w_push     = 1'b1;
            w_state_nx = PRESSED;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == CW'(DEBOUNCE)) begin
              w_state_nx = RELEASED;
              w_cnt_nx   = '0;
              w_flush    = 1'b1;
            end
          end
        end
        default: begin
          w_state_nx = RELEASED;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // ---------------- 4-deep averaging buffer, index 0 = newest ----------------
  logic [1:0][3:0][11:0] r_buf;
  logic [2:0]            r_fill;
  logic [1:0][11:0]      w_raw;

  assign w_raw = {bus.raw_y, bus.raw_x};

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (w_flush) begin
      r_buf  <= '0;
      r_fill <= '0;
    end else if (w_push) begin
      for (int a = 0; a < 2; a++) r_buf[a] <= {r_buf[a][2:0], w_raw[a]};
      r_fill <= (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
    end
  end

  logic [1:0][11:0] w_cal;

  for (genvar a = 0; a < 2; a++) begin : g_axis
    localparam int OFF = (a == 0) ? X_OFFSET : Y_OFFSET;
    localparam int SH  = (a == 0) ? X_SHIFT  : Y_SHIFT;
    localparam int MX  = (a == 0) ? X_MAX    : Y_MAX;

    logic [13:0] w_sum;
    logic [11:0] w_avg;

    assign w_sum = 14'(r_buf[a][0]) + 14'(r_buf[a][1]) +
                   14'(r_buf[a][2]) + 14'(r_buf[a][3]);

    // Three entries would need a divide by 3; use the newest sample instead.
    always_comb begin
      case (r_fill)
        3'd1:    w_avg = w_sum[11:0];
        3'd2:    w_avg = w_sum[12:1];
        3'd3:    w_avg = r_buf[a][0];
        3'd4:    w_avg = w_sum[13:2];
        default: w_avg = '0;
      endcase
    end

    assign w_cal[a] = calib(w_avg, 12'(OFF), SH, 12'(MX));
  end

  // ---------------- frame-stable output latch ----------------
  logic      w_active;
  touch_xy_t r_out;
  logic      r_valid;

  assign w_active = (r_state == PRESSED) || (r_state == REL_PEND);

  // Uses registered state/buffer, so a coincident sample tick shows next frame.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      r_out.x <= NO_TOUCH;
      r_out.y <= NO_TOUCH;
      r_valid <= 1'b0;
    end else if (w_frame_evt) begin
      r_valid <= w_active;
      r_out.x <= w_active ? w_cal[0] : NO_TOUCH;
      r_out.y <= w_active ? w_cal[1] : NO_TOUCH;
    end
  end

  assign bus.touch_x     = r_out.x;
  assign bus.touch_y     = r_out.y;
  assign bus.touch_valid = r_valid;
  assign bus.sample_tick = r_tick;

endmodule

// File: tb/tb_touch_frame_filter.sv
// Directed bench for touch_frame_filter with an abstract press/average model
// checked against the outputs every cycle, plus hand-computed spot values.
module tb_touch_frame_filter;
  localparam int DIV = 10;

  logic cclk;
  logic rstb;
  touch_frame_filter_if bus();

  touch_frame_filter #(.SAMPLE_DIV(DIV)) dut (
    .cclk (cclk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  // Press state flips after 3 consecutive samples disagreeing with it.
  bit m_pressed = 0;
  int m_run     = 0;
  int qx[$];
  int qy[$];
  int m_tx = 1000, m_ty = 1000;
  bit m_tv = 0;
  int m_e = 0;
  bit m_tick = 0;
  int m_nsamp = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  function automatic int mcal(input int axis);
    int n, s, avg, r, off, sh, mx, newest;
    n = (axis == 0) ? qx.size() : qy.size();
    s = 0;
    newest = 0;
    for (int i = 0; i < n; i++) begin
      newest = (axis == 0) ? qx[i] : qy[i];
      s += newest;
    end
    case (n)
      0:       avg = 0;
      1:       avg = s;
      2:       avg = s / 2;
      3:       avg = newest;
      default: avg = s / 4;
    endcase
    off = (axis == 0) ? 150 : 300;
    sh  = (axis == 0) ? 8 : 16;
    mx  = (axis == 0) ? 479 : 271;
    r = (avg < off) ? 0 : (avg - off) / sh;
    return (r > mx) ? mx : r;
  endfunction

  task automatic model_sample();
    bit hit;
    hit = (int'(bus.raw_z) >= 256);
    if (hit && (m_pressed || m_run > 0)) begin
      qx.push_back(int'(bus.raw_x));
      qy.push_back(int'(bus.raw_y));
      if (qx.size() > 4) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
    end
    if (hit != m_pressed) m_run++;
    else                  m_run = 0;
    if (m_run == 3) begin
      m_pressed = !m_pressed;
      m_run = 0;
    end
    if (!m_pressed && m_run == 0) begin
      qx.delete();
      qy.delete();
    end
    m_nsamp++;
  endtask

  initial begin
    forever begin
      @(posedge cclk or negedge rstb);
      if (!rstb) begin
        m_pressed = 0; m_run = 0; qx.delete(); qy.delete();
        m_tx = 1000; m_ty = 1000; m_tv = 0;
        m_e = 0; m_tick = 0; h1 = 0; h2 = 0; h3 = 0;
      end else begin
        // frame marker seen 2 edges after its rising sample
        if (h2 && !h3) begin
          m_tv = m_pressed;
          m_tx = m_pressed ? mcal(0) : 1000;
          m_ty = m_pressed ? mcal(1) : 1000;
        end
        if (m_tick) model_sample();
        h3 = h2; h2 = h1; h1 = bus.new_frame;
        m_e++;
        m_tick = (m_e % DIV == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge cclk);
      chk("cyc_touch_x", int'(bus.touch_x), m_tx);
      chk("cyc_touch_y", int'(bus.touch_y), m_ty);
      chk("cyc_touch_valid", int'(bus.touch_valid), int'(m_tv));
      chk("cyc_sample_tick", int'(bus.sample_tick), int'(m_tick));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int x, input int y, input int z);
    bus.raw_x = 12'(x);
    bus.raw_y = 12'(y);
    bus.raw_z = 12'(z);
  endtask

  task automatic ticks(input int n);
    int target;
    target = m_nsamp + n;
    while (m_nsamp < target) @(negedge cclk);
  endtask

  task automatic frame();
    bus.new_frame = 1'b1;
    repeat (4) @(negedge cclk);
    bus.new_frame = 1'b0;
    repeat (4) @(negedge cclk);
  endtask

  // Called right after a sample edge: the frame event lands on the next one.
  task automatic frame_at_tick();
    repeat (7) @(negedge cclk);
    frame();
  endtask

  task automatic expect_out(input string tag, input int v, input int x, input int y);
    chk({tag, "_valid"}, int'(bus.touch_valid), v);
    chk({tag, "_x"}, int'(bus.touch_x), x);
    chk({tag, "_y"}, int'(bus.touch_y), y);
    chk({tag, "_model_valid"}, int'(m_tv), v);
    chk({tag, "_model_x"}, m_tx, x);
    chk({tag, "_model_y"}, m_ty, y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb = 1'b0;
    bus.new_frame = 1'b0;
    set_in(950, 1900, 4000);
    repeat (3) begin
      repeat (3) @(negedge cclk);
      bus.new_frame = 1'b1;
      repeat (3) @(negedge cclk);
      bus.new_frame = 1'b0;
    end
    expect_out("reset", 0, 1000, 1000);
    chk("reset_tick", int'(bus.sample_tick), 0);

    @(negedge cclk);
    rstb = 1'b1;
    set_in(950, 1900, 600);
    ticks(3);
    frame();
    expect_out("press", 1, 100, 100);

    set_in(1110, 1900, 600);
    ticks(4);
    expect_out("hold", 1, 100, 100);
    frame();
    expect_out("update", 1, 120, 100);

    set_in(100, 4095, 600);
    ticks(4);
    frame();
    expect_out("underflow", 1, 0, 237);
    set_in(4095, 4095, 600);
    ticks(4);
    frame();
    expect_out("clamp", 1, 479, 237);

    set_in(800, 1900, 600);
    ticks(3);
    set_in(1600, 1900, 600);
    ticks(1);
    frame();
    expect_out("average", 1, 106, 100);

    set_in(1600, 1900, 0);
    ticks(1);
    set_in(1600, 1900, 600);
    ticks(1);
    frame();
    expect_out("drop1", 1, 131, 100);

    set_in(1600, 1900, 0);
    ticks(1);
    frame();
    expect_out("relpend", 1, 131, 100);
    ticks(2);
    frame();
    expect_out("release", 0, 1000, 1000);

    set_in(950, 1900, 600);
    ticks(2);
    frame();
    expect_out("pending", 0, 1000, 1000);
    set_in(950, 1900, 0);
    ticks(1);
    frame();
    expect_out("glitch", 0, 1000, 1000);

    set_in(950, 1900, 600);
    ticks(2);
    frame_at_tick();
    expect_out("coincide", 0, 1000, 1000);
    frame();
    expect_out("after_coincide", 1, 100, 100);

    #3 rstb = 1'b0;
    #1 expect_out("async_rst", 0, 1000, 1000);
    repeat (3) @(negedge cclk);
    rstb = 1'b1;
    ticks(1);
    frame();
    expect_out("post_rst", 0, 1000, 1000);

    repeat (5) @(negedge cclk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
